// File: rtl/individual_fitness_scorer.sv
// Scores an evolved individual's four output words against golden values:
// a three-stage pipeline sums the Hamming error into a saturating accumulator and counts exact-match samples.
module individual_fitness_scorer #(
  parameter int unsigned W     = 16,
  parameter int unsigned ACC_W = 24,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     y3,
  input  logic [W-1:0]     y2,
  input  logic [W-1:0]     y1,
  input  logic [W-1:0]     y0,
  input  logic [W-1:0]     e3,
  input  logic [W-1:0]     e2,
  input  logic [W-1:0]     e1,
  input  logic [W-1:0]     e0,
  output logic             done,
  output logic [ACC_W-1:0] score,
  output logic [CNT_W-1:0] exact_hits,
  output logic             sat
);

  localparam int unsigned ERR_W = $clog2(4 * W + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               s1_v_q, s1_v_d;
  logic [4*W-1:0]     x_q, x_d;
  logic               s2_v_q, s2_v_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               zero_q, zero_d;
  logic [ACC_W-1:0]   score_q, score_d;
  logic [CNT_W-1:0]   hits_q, hits_d;
  logic               sat_q, sat_d;
  logic               accept;
  logic [ACC_W:0]     sum;
  logic [CNT_W-1:0]   cnt_inc;

  assign in_ready   = (state_q == RUN) && (cnt_q < n_q);
  assign accept     = in_valid && in_ready;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign score      = score_q;
  assign exact_hits = hits_q;
  assign sat        = sat_q;
  assign cnt_inc    = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    score_d = score_q;
    hits_d  = hits_q;
    sat_d   = sat_q;
    sum     = '0;

    // S1: per-word difference bits
    s1_v_d = accept;
    x_d    = accept ? {y3 ^ e3, y2 ^ e2, y1 ^ e1, y0 ^ e0} : x_q;

    // S2: total error and exact-match flag
    s2_v_d = s1_v_q;
    err_d  = '0;
    for (int unsigned i = 0; i < 4 * W; i++) begin
      err_d = err_d + ERR_W'(x_q[i]);
    end
    zero_d = (x_q == '0);

    // S3: accumulate with clamp at all-ones
    if (s2_v_q) begin
      sum = {1'b0, score_q} + (ACC_W + 1)'(err_q);
      if (sum[ACC_W]) begin
        score_d = '1;
        sat_d   = 1'b1;
      end else begin
        score_d = sum[ACC_W-1:0];
      end
      if (zero_q) hits_d = hits_q + CNT_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          n_d     = num_samples;
          cnt_d   = '0;
          score_d = '0;
          hits_d  = '0;
          sat_d   = 1'b0;
          state_d = (num_samples != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (cnt_inc == n_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // S3 has already committed once both earlier stages are empty
        if (!s1_v_q && !s2_v_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      cnt_q   <= '0;
      s1_v_q  <= 1'b0;
      x_q     <= '0;
      s2_v_q  <= 1'b0;
      err_q   <= '0;
      zero_q  <= 1'b0;
      score_q <= '0;
      hits_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      s1_v_q  <= s1_v_d;
      x_q     <= x_d;
      s2_v_q  <= s2_v_d;
      err_q   <= err_d;
      zero_q  <= zero_d;
      score_q <= score_d;
      hits_q  <= hits_d;
      sat_q   <= sat_d;
    end
  end

endmodule

// File: tb/tb_individual_fitness_scorer.sv
// Bench for individual_fitness_scorer: a 24-bit and an 8-bit accumulator instance share one stimulus stream;
// results are compared against a Hamming-distance reference model.
module tb_individual_fitness_scorer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] num_samples = '0;
  logic [63:0] ycur = '0;
  logic [63:0] ecur = '0;

  logic        busy, in_ready, done, sat;
  logic [23:0] score;
  logic [15:0] hits;
  logic        busy8, in_ready8, done8, sat8;
  logic [7:0]  score8;
  logic [15:0] hits8;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] ys[0:63];
  logic [63:0] es[0:63];

  always #5 clk = ~clk;

  individual_fitness_scorer #(.W(16), .ACC_W(24), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready),
    .y3(ycur[63:48]), .y2(ycur[47:32]), .y1(ycur[31:16]), .y0(ycur[15:0]),
    .e3(ecur[63:48]), .e2(ecur[47:32]), .e1(ecur[31:16]), .e0(ecur[15:0]),
    .done(done), .score(score), .exact_hits(hits), .sat(sat)
  );

  individual_fitness_scorer #(.W(16), .ACC_W(8), .CNT_W(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples), .busy(busy8),
    .in_valid(in_valid), .in_ready(in_ready8),
    .y3(ycur[63:48]), .y2(ycur[47:32]), .y1(ycur[31:16]), .y0(ycur[15:0]),
    .e3(ecur[63:48]), .e2(ecur[47:32]), .e1(ecur[31:16]), .e0(ecur[15:0]),
    .done(done8), .score(score8), .exact_hits(hits8), .sat(sat8)
  );

  // Reference model: Hamming distance per sample, clamped running total
  function automatic int perr(input logic [63:0] y, input logic [63:0] e);
    int c = 0;
    for (int i = 0; i < 64; i++) c += int'(y[i] ^ e[i]);
    return c;
  endfunction

  function automatic longint model_score(input int n, input longint maxv);
    longint s = 0;
    for (int k = 0; k < n; k++) s += perr(ys[k], es[k]);
    return (s > maxv) ? maxv : s;
  endfunction

  function automatic bit model_sat(input int n, input longint maxv);
    longint s = 0;
    for (int k = 0; k < n; k++) s += perr(ys[k], es[k]);
    return s > maxv;
  endfunction

  function automatic int model_hits(input int n);
    int h = 0;
    for (int k = 0; k < n; k++) if (perr(ys[k], es[k]) == 0) h++;
    return h;
  endfunction

  // Stimulus driver: starts a run (with a bogus in_valid alongside start), feeds ys/es with random gaps,
  // optionally keeps in_valid high after the last sample, and reports done latency from the final accept.
  task automatic run(input int n, input int gap_pct, input bit extra,
                     output int lat, output int nacc, output int ready_late);
    int idx, e, last_acc;
    bit acc;
    idx = 0; e = 0; last_acc = 0; lat = -1; nacc = 0; ready_late = 0;
    @(negedge clk);
    start = 1'b1; num_samples = 16'(n);
    in_valid = 1'b1; ycur = '1; ecur = '0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 3000 && lat < 0; c++) begin
      if (done) begin
        lat = e - last_acc;
      end else begin
        if ((idx < n || extra) && $urandom_range(99) >= gap_pct) begin
          in_valid = 1'b1; ycur = ys[idx]; ecur = es[idx];
        end else begin
          in_valid = 1'b0;
        end
        if (nacc >= n && in_ready) ready_late++;
        acc = in_valid && in_ready;
        @(posedge clk);
        e++;
        if (acc) begin idx++; nacc++; last_acc = e; end
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({busy, in_ready, done, sat, score, hits} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b rdy=%b done=%b sat=%b score=%0d hits=%0d, required all 0",
               busy, in_ready, done, sat, score, hits);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_exact_single;
    int lat, nacc, rl;
    ys[0] = {4{16'h1234}}; es[0] = {4{16'h1234}};
    run(1, 0, 1'b0, lat, nacc, rl);
    vectors++;
    if (score !== 24'd0 || hits !== 16'd1 || lat !== 3) begin
      miscompares++;
      $display("FAIL exact_single: score=%0d hits=%0d lat=%0d, required 0 1 3", score, hits, lat);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL done_one_cycle: done=%b busy=%b, required 0 0", done, busy);
    end
  endtask

  task automatic test_back_to_back;
    int lat, nacc, rl;
    for (int k = 0; k < 4; k++) begin ys[k] = '1; es[k] = '0; end
    run(4, 0, 1'b1, lat, nacc, rl);
    vectors++;
    if (score !== 24'd256 || hits !== 16'd0 || lat !== 3) begin
      miscompares++;
      $display("FAIL back_to_back: score=%0d hits=%0d lat=%0d, required 256 0 3", score, hits, lat);
    end
    vectors++;
    if (rl !== 0 || nacc !== 4) begin
      miscompares++;
      $display("FAIL ready_drop: late_ready_cycles=%0d accepted=%0d, required 0 4", rl, nacc);
    end
  endtask

  task automatic test_gaps_extra;
    int lat, nacc, rl;
    for (int k = 0; k < 3; k++) begin
      es[k] = {$urandom, $urandom};
      ys[k] = es[k] ^ (64'd1 << $urandom_range(63));
    end
    ys[3] = '1; es[3] = '0;
    run(3, 40, 1'b1, lat, nacc, rl);
    vectors++;
    if (score !== 24'd3 || hits !== 16'd0 || nacc !== 3 || lat !== 3) begin
      miscompares++;
      $display("FAIL gaps_extra: score=%0d hits=%0d acc=%0d lat=%0d, required 3 0 3 3", score, hits, nacc, lat);
    end
  endtask

  task automatic test_saturation;
    int lat, nacc, rl;
    for (int k = 0; k < 5; k++) begin ys[k] = '1; es[k] = '0; end
    run(5, 0, 1'b0, lat, nacc, rl);
    vectors++;
    if (score8 !== 8'd255 || sat8 !== 1'b1 || done8 !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_narrow: score=%0d sat=%b done=%b, required 255 1 1", score8, sat8, done8);
    end
    vectors++;
    if (score !== 24'd320 || sat !== 1'b0) begin
      miscompares++;
      $display("FAIL sat_wide: score=%0d sat=%b, required 320 0", score, sat);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (score8 !== 8'd255 || sat8 !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_hold: score=%0d sat=%b, required 255 1", score8, sat8);
    end
    ys[0] = 64'h0123_4567_89ab_cdef; es[0] = ys[0];
    run(1, 0, 1'b0, lat, nacc, rl);
    vectors++;
    if (sat8 !== 1'b0 || score8 !== 8'd0 || hits8 !== 16'd1) begin
      miscompares++;
      $display("FAIL sat_clear: sat=%b score=%0d hits=%0d, required 0 0 1", sat8, score8, hits8);
    end
  endtask

  task automatic test_reset_mid_run;
    @(negedge clk);
    start = 1'b1; num_samples = 16'd10;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; ycur = '1; ecur = '0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, in_ready, done, sat, score, hits} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_run: busy=%b rdy=%b done=%b sat=%b score=%0d hits=%0d, required all 0",
               busy, in_ready, done, sat, score, hits);
    end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL stale_done: cycle=%0d done=%b busy=%b, required 0 0", c, done, busy);
      end
    end
    start = 1'b1; num_samples = 16'd0;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (done !== 1'b1 || score !== 24'd0 || hits !== 16'd0) begin
      miscompares++;
      $display("FAIL zero_run: done=%b score=%0d hits=%0d, required 1 0 0", done, score, hits);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_run_end: done=%b busy=%b, required 0 0", done, busy);
    end
  endtask

  task automatic test_random;
    int lat, nacc, rl, n;
    longint es24, es8;
    int eh;
    bit esat8;
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(40, 1);
      for (int k = 0; k <= n; k++) begin
        es[k] = {$urandom, $urandom};
        case ($urandom_range(2))
          0:       ys[k] = es[k];
          1:       ys[k] = es[k] ^ ({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
          default: ys[k] = {$urandom, $urandom};
        endcase
      end
      es24  = model_score(n, 64'd16777215);
      es8   = model_score(n, 64'd255);
      esat8 = model_sat(n, 64'd255);
      eh    = model_hits(n);
      run(n, 25, 1'($urandom_range(1)), lat, nacc, rl);
      vectors++;
      if (longint'(score) !== es24 || int'(hits) !== eh || lat !== 3 || nacc !== n || rl !== 0) begin
        miscompares++;
        $display("FAIL random_wide[%0d]: score=%0d hits=%0d lat=%0d acc=%0d late=%0d, required %0d %0d 3 %0d 0",
                 r, score, hits, lat, nacc, rl, es24, eh, n);
      end
      vectors++;
      if (longint'(score8) !== es8 || sat8 !== esat8 || int'(hits8) !== eh || done8 !== 1'b1) begin
        miscompares++;
        $display("FAIL random_narrow[%0d]: score=%0d sat=%b hits=%0d done=%b, required %0d %b %0d 1",
                 r, score8, sat8, hits8, done8, es8, esat8, eh);
      end
      repeat ($urandom_range(3)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_exact_single();
    test_back_to_back();
    test_gaps_extra();
    test_saturation();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
